// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: requester IDs, the in-flight command tag
// and default bus widths.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VID  = 2'd1,
        REQ_CPU  = 2'd2,
        REQ_DMA  = 2'd3
    } req_id_e;

    // Travels with a command from the command stage to the read-return stage.
    typedef struct packed {
        req_id_e id;
        logic    is_read;
    } tag_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker. Requester A wins when alone or when B won the
// previous tie; B wins when alone or when A won the previous tie.
module sram_arb_rr (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    // rr_last: 0 = A won the last tie, 1 = B won the last tie.
    logic rr_last;

    // Combinational pick; en masks both grants when a higher-priority master owns the slot.
    always_comb begin
        gnt_a = en & req_a & (~req_b | rr_last);
        gnt_b = en & req_b & (~req_a | ~rr_last);
    end

    // Remember the tie winner; reset favours A as last so B wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b0;
        end else if (en && req_a && req_b) begin
            rr_last <= gnt_b;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port async SRAM arbiter: video has absolute priority, CPU and DMA
// share leftover slots round-robin. One registered command per cycle, read
// data returned two cycles after grant with a per-requester valid.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk_core,
    input  logic              core_reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_wr,
    output logic [DATA_W-1:0] host_to_sram,
    input  logic [DATA_W-1:0] sram_to_host,
    output logic              cpu_starve,
    input  logic              cpu_starve_clr
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic              rr_cpu;
    logic              rr_dma;
    req_id_e           winner;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_write;
    logic              win_read;
    tag_t              tag_p0;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_next;
    logic              starve_set;

    sram_arb_rr u_rr (
        .clk   (clk_core),
        .rst_n (core_reset_n),
        .en    (~vid_req),
        .req_a (cpu_req),
        .req_b (dma_req),
        .gnt_a (rr_cpu),
        .gnt_b (rr_dma)
    );

    // Arbitration: video preempts, otherwise the round-robin pick; grants are held low in reset.
    always_comb begin
        cpu_gnt   = core_reset_n & rr_cpu;
        dma_gnt   = core_reset_n & rr_dma;
        winner    = REQ_NONE;
        win_addr  = sram_a;
        win_wdata = host_to_sram;
        win_write = 1'b0;
        win_read  = 1'b0;
        if (vid_req) begin
            winner   = REQ_VID;
            win_addr = vid_addr;
            win_read = 1'b1;
        end else if (cpu_gnt) begin
            winner    = REQ_CPU;
            win_addr  = cpu_addr;
            win_wdata = cpu_wdata;
            win_write = cpu_we;
            win_read  = ~cpu_we;
        end else if (dma_gnt) begin
            winner    = REQ_DMA;
            win_addr  = dma_addr;
            win_wdata = dma_wdata;
            win_write = dma_we;
            win_read  = ~dma_we;
        end
    end

    // Command stage (_p0): drive the SRAM pins for the access in the next cycle.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            sram_a       <= '0;
            sram_wr      <= 1'b0;
            host_to_sram <= '0;
            tag_p0       <= '{id: REQ_NONE, is_read: 1'b0};
        end else begin
            sram_a       <= win_addr;
            sram_wr      <= win_write;
            host_to_sram <= win_wdata;
            tag_p0       <= '{id: winner, is_read: win_read};
        end
    end

    // Return stage (_p1): capture SRAM read data and raise the owner's rvalid for one cycle.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            rdata      <= '0;
            vid_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            vid_rvalid <= tag_p0.is_read && (tag_p0.id == REQ_VID);
            cpu_rvalid <= tag_p0.is_read && (tag_p0.id == REQ_CPU);
            dma_rvalid <= tag_p0.is_read && (tag_p0.id == REQ_DMA);
            if (tag_p0.is_read) begin
                rdata <= sram_to_host;
            end
        end
    end

    // Starvation counter: counts denied CPU cycles, saturating at the limit.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (!cpu_req || cpu_gnt) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != CNT_W'(STARVE_LIMIT)) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
        starve_set = (wait_cnt_next == CNT_W'(STARVE_LIMIT));
    end

    // Sticky starve flag; a set in the same cycle as a clear takes precedence.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            wait_cnt   <= '0;
            cpu_starve <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (starve_set) begin
                cpu_starve <= 1'b1;
            end else if (cpu_starve_clr) begin
                cpu_starve <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a vector table for arbitration, command and
// read-return timing, plus hand-written sequences for priority, write-then-read,
// starvation, reset mid-access and withdrawn requests.
module tb_sram_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk_core = 1'b0;
    logic          core_reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_rvalid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] sram_a;
    logic          sram_wr;
    logic [DW-1:0] host_to_sram;
    logic [DW-1:0] sram_to_host;
    logic          cpu_starve;
    logic          cpu_starve_clr;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(64)) dut (
        .clk_core       (clk_core),
        .core_reset_n   (core_reset_n),
        .vid_req        (vid_req),
        .vid_addr       (vid_addr),
        .vid_rvalid     (vid_rvalid),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_rvalid     (cpu_rvalid),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_gnt        (dma_gnt),
        .dma_rvalid     (dma_rvalid),
        .rdata          (rdata),
        .sram_a         (sram_a),
        .sram_wr        (sram_wr),
        .host_to_sram   (host_to_sram),
        .sram_to_host   (sram_to_host),
        .cpu_starve     (cpu_starve),
        .cpu_starve_clr (cpu_starve_clr)
    );

    always #5 clk_core = ~clk_core;

    // Async SRAM model: combinational read, write committed at the end of the write cycle.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk_core) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (sram_wr) mem[sram_a] <= host_to_sram;
    end
    assign sram_to_host = mem[sram_a];

    typedef struct {
        logic          vid;
        logic [AW-1:0] va;
        logic          creq;
        logic          cwe;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          e_cg;
        logic          e_dg;
        logic [AW-1:0] e_a;
        logic          e_wr;
        logic [DW-1:0] e_wd;
        logic          e_vrv;
        logic          e_crv;
        logic          e_drv;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic idle_inputs();
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        cpu_starve_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        core_reset_n = 1'b0;
        tick();
        tick();
        core_reset_n = 1'b1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        vid_req = v.vid;  vid_addr = v.va;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.ca; cpu_wdata = v.cd;
        dma_req = v.dreq; dma_we = v.dwe; dma_addr = v.da; dma_wdata = v.dd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int seen_g;
        int seen_rv;
        int seen_wr;
        logic [0:7] ecg;
        logic [0:7] edg;
        logic [0:7] evrv;
        logic [0:7] ecrv;
        logic [0:7] edrv;

        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        idle_inputs();
        core_reset_n = 1'b0;
        #1;
        preload(14'h0010, 16'hBEEF);
        preload(14'h0030, 16'h3030);
        preload(14'h0040, 16'h4040);
        preload(14'h0050, 16'h5050);
        preload(14'h0070, 16'h0707);

        // Reset state, with requests present that must not be granted.
        cpu_req = 1'b1; dma_req = 1'b1; vid_req = 1'b0;
        #1;
        chk("rst_sram_a", sram_a, 0);
        chk("rst_sram_wr", sram_wr, 0);
        chk("rst_host_to_sram", host_to_sram, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalids", {vid_rvalid, cpu_rvalid, dma_rvalid}, 0);
        chk("rst_gnts", {cpu_gnt, dma_gnt}, 0);
        chk("rst_starve", cpu_starve, 0);
        do_reset();

        // ---------------- vector table ----------------
        tbl[0] = '{1'b0, 14'h0,   1'b0, 1'b0, 14'h0,   16'h0,    1'b0, 1'b0, 14'h0,   16'h0,
                   1'b0, 1'b0, 14'h0,   1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0};
        tbl[1] = '{1'b0, 14'h0,   1'b1, 1'b0, 14'h010, 16'h0,    1'b0, 1'b0, 14'h0,   16'h0,
                   1'b1, 1'b0, 14'h010, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0};
        tbl[2] = '{1'b0, 14'h0,   1'b0, 1'b0, 14'h0,   16'h0,    1'b1, 1'b1, 14'h020, 16'hAAAA,
                   1'b0, 1'b1, 14'h020, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[3] = '{1'b1, 14'h030, 1'b1, 1'b0, 14'h040, 16'h0,    1'b1, 1'b0, 14'h050, 16'h0,
                   1'b0, 1'b0, 14'h030, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 16'hBEEF};
        tbl[4] = '{1'b0, 14'h0,   1'b1, 1'b0, 14'h040, 16'h0,    1'b1, 1'b0, 14'h050, 16'h0,
                   1'b0, 1'b1, 14'h050, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0};
        tbl[5] = '{1'b0, 14'h0,   1'b1, 1'b0, 14'h040, 16'h0,    1'b1, 1'b0, 14'h050, 16'h0,
                   1'b1, 1'b0, 14'h040, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 16'h3030};
        tbl[6] = '{1'b0, 14'h0,   1'b0, 1'b0, 14'h0,   16'h0,    1'b0, 1'b0, 14'h0,   16'h0,
                   1'b0, 1'b0, 14'h040, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 16'h5050};
        tbl[7] = '{1'b0, 14'h0,   1'b1, 1'b1, 14'h060, 16'h5555, 1'b0, 1'b0, 14'h0,   16'h0,
                   1'b1, 1'b0, 14'h060, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h4040};
        tbl[8] = '{1'b0, 14'h0,   1'b0, 1'b0, 14'h0,   16'h0,    1'b0, 1'b0, 14'h0,   16'h0,
                   1'b0, 1'b0, 14'h060, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0};
        tbl[9] = tbl[8];

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_cpu_gnt", i), cpu_gnt, tbl[i].e_cg);
            chk($sformatf("tbl%0d_dma_gnt", i), dma_gnt, tbl[i].e_dg);
            chk($sformatf("tbl%0d_rvalids", i), {vid_rvalid, cpu_rvalid, dma_rvalid},
                {tbl[i].e_vrv, tbl[i].e_crv, tbl[i].e_drv});
            if (tbl[i].e_vrv || tbl[i].e_crv || tbl[i].e_drv)
                chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rd);
            tick();
            chk($sformatf("tbl%0d_sram_a", i), sram_a, tbl[i].e_a);
            chk($sformatf("tbl%0d_sram_wr", i), sram_wr, tbl[i].e_wr);
            if (tbl[i].e_wr)
                chk($sformatf("tbl%0d_host_to_sram", i), host_to_sram, tbl[i].e_wd);
        end

        // ---------------- video priority, then DMA-first alternation ----------------
        do_reset();
        ecg  = 8'b0000_0101;
        edg  = 8'b0000_1010;
        evrv = 8'b0011_1100;
        ecrv = 8'b0000_0001;
        edrv = 8'b0000_0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h040;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h050;
        for (int c = 0; c < 8; c++) begin
            vid_req = (c < 4); vid_addr = 14'h030;
            #1;
            chk($sformatf("prio%0d_cpu_gnt", c), cpu_gnt, ecg[c]);
            chk($sformatf("prio%0d_dma_gnt", c), dma_gnt, edg[c]);
            chk($sformatf("prio%0d_rvalids", c), {vid_rvalid, cpu_rvalid, dma_rvalid},
                {evrv[c], ecrv[c], edrv[c]});
            tick();
        end
        idle_inputs();

        // ---------------- write then read same address ----------------
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h100; cpu_wdata = 16'h1234;
        #1;
        chk("wr_cpu_gnt", cpu_gnt, 1);
        tick();
        chk("wr_sram_wr", sram_wr, 1);
        chk("wr_sram_a", sram_a, 14'h100);
        chk("wr_host_to_sram", host_to_sram, 16'h1234);
        cpu_we = 1'b0; cpu_wdata = 16'h0;
        #1;
        chk("rd_cpu_gnt", cpu_gnt, 1);
        tick();
        chk("rd_sram_wr_low", sram_wr, 0);
        chk("rd_sram_a", sram_a, 14'h100);
        cpu_req = 1'b0;
        #1;
        chk("wr_no_rvalid", cpu_rvalid, 0);
        tick();
        #1;
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", rdata, 16'h1234);
        tick();
        chk("rd_rvalid_one_cycle", cpu_rvalid, 0);

        // ---------------- starvation ----------------
        do_reset();
        vid_req = 1'b1; vid_addr = 14'h030;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h040;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 63) chk("starve_63", cpu_starve, 0);
            if (k == 64) chk("starve_64", cpu_starve, 1);
        end
        cpu_starve_clr = 1'b1;
        tick();
        cpu_starve_clr = 1'b0;
        chk("starve_set_beats_clr", cpu_starve, 1);
        vid_req = 1'b0;
        #1;
        chk("starve_cpu_gnt", cpu_gnt, 1);
        tick();
        cpu_req = 1'b0;
        chk("starve_sticky", cpu_starve, 1);
        tick();
        chk("starve_sticky2", cpu_starve, 1);
        cpu_starve_clr = 1'b1;
        tick();
        cpu_starve_clr = 1'b0;
        chk("starve_cleared", cpu_starve, 0);

        // ---------------- reset during a DMA read ----------------
        do_reset();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h050;
        #1;
        chk("rstrd_dma_gnt", dma_gnt, 1);
        tick();
        dma_req = 1'b0;
        #2;
        core_reset_n = 1'b0;
        #1;
        chk("rstrd_sram_a_async", sram_a, 0);
        seen_rv = 0;
        tick();
        core_reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (dma_rvalid) seen_rv++;
            tick();
        end
        chk("rstrd_no_dma_rvalid", seen_rv, 0);

        // Reset while a DMA write is on the pins: sram_wr must drop without a clock.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h070; dma_wdata = 16'h7777;
        #1;
        chk("rstwr_dma_gnt", dma_gnt, 1);
        tick();
        dma_req = 1'b0; dma_we = 1'b0;
        chk("rstwr_sram_wr_high", sram_wr, 1);
        #2;
        core_reset_n = 1'b0;
        #1;
        chk("rstwr_sram_wr_async", sram_wr, 0);
        tick();
        core_reset_n = 1'b1;
        chk("rstwr_mem_untouched", mem[14'h070], 16'h0707);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h040;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h050;
        #1;
        chk("rst_tie_dma_gnt", dma_gnt, 1);
        chk("rst_tie_cpu_gnt", cpu_gnt, 0);
        tick();
        idle_inputs();

        // ---------------- DMA request withdrawn under video ----------------
        do_reset();
        seen_g = 0; seen_rv = 0; seen_wr = 0;
        vid_req = 1'b1; vid_addr = 14'h030;
        dma_we = 1'b1; dma_addr = 14'h020; dma_wdata = 16'hDEAD;
        for (int c = 0; c < 8; c++) begin
            dma_req = (c >= 1 && c <= 3);
            if (c == 6) vid_req = 1'b0;
            #1;
            if (dma_gnt) seen_g++;
            if (dma_rvalid) seen_rv++;
            if (sram_wr) seen_wr++;
            tick();
        end
        idle_inputs();
        chk("wd_no_dma_gnt", seen_g, 0);
        chk("wd_no_dma_rvalid", seen_rv, 0);
        chk("wd_no_sram_wr", seen_wr, 0);
        chk("wd_mem_untouched", mem[14'h020], 16'hAAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external async SRAM port between three requesters: video scanout, the CPU, and a DMA engine (SD/flash loader).
- Sits between the SoC masters and the top-level SRAM pins. Its outputs drive the SRAM address, write-enable request and write data; the top level generates the physical WE/OE strobes from the quarter-phase clock.
- Video has absolute priority. CPU and DMA share the remaining slots round-robin.
- Issues one SRAM access per cycle, with a registered command stage and routed read-data return.

Parameters:
- ADDR_W, 14, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- STARVE_LIMIT, 64, consecutive denied CPU cycles before cpu_starve is raised.

Ports:
- clk_core  in  1  core clock; all state is rising-edge.
- core_reset_n  in  1  asynchronous active-low reset.
- vid_req  in  1  video read request. Always granted in the same cycle.
- vid_addr  in  ADDR_W  video read address.
- vid_rvalid  out  1  video read data valid.
- cpu_req / dma_req  in  1  access request. Held until granted.
- cpu_we / dma_we  in  1  1 = write, 0 = read.
- cpu_addr / dma_addr  in  ADDR_W  word address.
- cpu_wdata / dma_wdata  in  DATA_W  write data.
- cpu_gnt / dma_gnt  out  1  combinational grant; the command is accepted this cycle.
- cpu_rvalid / dma_rvalid  out  1  read data valid for that requester.
- rdata  out  DATA_W  registered read data, shared by all requesters and qualified by the rvalid lines.
- sram_a  out  ADDR_W  registered SRAM address.
- sram_wr  out  1  registered write-cycle flag.
- host_to_sram  out  DATA_W  registered write data.
- sram_to_host  in  DATA_W  SRAM read data.
- cpu_starve  out  1  sticky flag: the CPU waited STARVE_LIMIT cycles.
- cpu_starve_clr  in  1  clears cpu_starve.

Behaviour:
- Reset (async, core_reset_n=0) clears:
  - sram_a, sram_wr, host_to_sram, rdata to 0;
  - all rvalid and gnt outputs to 0;
  - rr_last to CPU, so DMA wins the first tie;
  - the wait counter and cpu_starve.
- Reset mid-access abandons the access. No rvalid is produced for it, and sram_wr is deasserted asynchronously.
- Arbitration (combinational, cycle N):
  - vid_req=1: video wins; cpu_gnt=dma_gnt=0.
  - Else if only one of cpu_req/dma_req is set, that requester wins.
  - Else if both are set, the one not equal to rr_last wins, and rr_last updates to the winner at the edge.
  - No request: idle. sram_wr is 0 next cycle and sram_a holds its previous value.
- Command stage (edge ending N), for the winner:
  - sram_a <= addr;
  - sram_wr <= we (always 0 for video);
  - host_to_sram <= wdata;
  - tag register <= {winner, is_read}.
- Cycle N+1: SRAM access occurs. For reads, rdata <= sram_to_host at the edge ending N+1.
- Cycle N+2: the matching rvalid is high for exactly one cycle. Writes produce no rvalid.
- Read latency is fixed at 2 cycles from grant. The pipeline is fully back-to-back: a new grant every cycle, with at most 2 commands in flight.
- Requester rules:
  - Addr, we and wdata must be stable while req is high.
  - The requester may change them or drop req in the cycle after gnt.
  - Dropping req before gnt is legal; the request is withdrawn with no side effects.
- Starvation:
  - The counter increments each cycle cpu_req=1 and cpu_gnt=0, saturating at STARVE_LIMIT.
  - It clears when cpu_gnt=1 or cpu_req=0.
  - Reaching STARVE_LIMIT sets cpu_starve.
  - cpu_starve clears only on cpu_starve_clr. If clr and set coincide, set wins.
- Write-then-read to the same address on consecutive grants returns the new data; the SRAM is written within cycle N+1.

Decomposition:
- Shared package sram_arb_pkg holds:
  - requester ID enum: REQ_NONE, REQ_VID, REQ_CPU, REQ_DMA;
  - the tag struct;
  - ADDR_W/DATA_W defaults.
- One natural sub-module: sram_arb_rr, a 2-way round-robin picker with rr_last state. It is reusable for adding requesters later.

Test Plan:
- Reset, then cpu_req read addr 0x0010 (SRAM model holds 0xBEEF) → cpu_gnt same cycle; sram_a=0x0010 next cycle; cpu_rvalid=1 with rdata=0xBEEF 2 cycles after grant; sram_wr=0 throughout.
- vid_req, cpu_req and dma_req all held high for 4 cycles → only video granted (vid_rvalid 4 consecutive cycles at +2). Then video drops: DMA is granted first, then CPU and DMA alternate each cycle.
- CPU write 0x1234→0x0100, then CPU read 0x0100 on the next cycle → sram_wr high for exactly one cycle with host_to_sram=0x1234; read returns 0x1234 with cpu_rvalid at +2.
- vid_req held and cpu_req held for 64 cycles → cpu_starve rises on cycle 64 and stays high after video drops. cpu_starve_clr pulse → 0.
- core_reset_n asserted in the cycle after a DMA read grant → dma_rvalid never asserts, sram_wr=0 immediately, and the first post-reset tie goes to DMA.
- dma_req raised then dropped while video holds the port → no dma_gnt, no dma_rvalid, no SRAM write ever observed.
